m_dm: RTL

M_DM -- requirements
Module: m_dm

---
 rtl/m_dm.sv | 121 ++++++++++++
 1 files changed

// File: rtl/m_dm.sv
// Data memory for the M stage: 3072 x 32-bit words with byte/half/word loads and stores.
// Define DM_DISPLAY_EN to log every performed store to the simulation console.
module m_dm (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        DMWE,
    input  logic [2:0]  DMOp,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades
);

    localparam int unsigned DEPTH = 3072;
    localparam logic [31:0] ADDR_LIMIT = 32'h0000_3000;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_HU = 3'b001;
    localparam logic [2:0] OP_HS = 3'b010;
    localparam logic [2:0] OP_BU = 3'b011;
    localparam logic [2:0] OP_BS = 3'b100;

    logic [31:0] mem [DEPTH];

    logic [11:0] widx;
    logic        reserved;
    logic        is_half;
    logic        is_byte;
    logic        out_of_range;
    logic        misaligned;
    logic        store_en;
    logic [31:0] word_rd;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] bit_mask;
    logic [31:0] merged;

    // Extract and extend the addressed half/byte; reserved ops fall through as word loads.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  op,
                                             input logic [1:0]  off);
        logic [15:0]        h;
        logic [31:0]        shifted;
        logic [7:0]         b;
        logic signed [15:0] hs;
        logic signed [7:0]  bs;
        logic signed [31:0] ext;
        h       = off[1] ? w[31:16] : w[15:0];
        shifted = w >> {off, 3'b000};
        b       = shifted[7:0];
        hs      = signed'(h);
        bs      = signed'(b);
        case (op)
            OP_HU:   return {16'h0000, h};
            OP_HS:   begin ext = hs; return ext; end
            OP_BU:   return {24'h00_0000, b};
            OP_BS:   begin ext = bs; return ext; end
            default: return w;
        endcase
    endfunction

    assign widx         = addr[13:2];
    assign reserved     = (DMOp > OP_BS);
    assign is_half      = (DMOp == OP_HU) || (DMOp == OP_HS);
    assign is_byte      = (DMOp == OP_BU) || (DMOp == OP_BS);
    assign out_of_range = (addr >= ADDR_LIMIT);

    always_comb begin
        misaligned = 1'b0;
        if (is_half)
            misaligned = addr[0];
        else if (!is_byte)
            misaligned = (addr[1:0] != 2'b00);
    end

    assign adel     = misaligned || out_of_range;
    assign ades     = DMWE && !reserved && adel;
    assign store_en = DMWE && !reserved && !adel;

    // Out-of-range addresses would index past the array, so gate the read.
    assign word_rd = out_of_range ? 32'h0000_0000 : mem[widx];
    assign rdata   = adel ? 32'h0000_0000 : load_ext(word_rd, DMOp, addr[1:0]);

    always_comb begin
        lane_en   = 4'b1111;
        lane_data = wdata;
        if (is_half) begin
            lane_data = {2{wdata[15:0]}};
            lane_en   = addr[1] ? 4'b1100 : 4'b0011;
        end else if (is_byte) begin
            lane_data = {4{wdata[7:0]}};
            lane_en   = 4'b0001 << addr[1:0];
        end
    end

    assign bit_mask = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
    assign merged   = (word_rd & ~bit_mask) | (lane_data & bit_mask);

    // Reset wins over a coincident store; the store is simply lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 32'h0000_0000;
        end else if (store_en) begin
            mem[widx] <= merged;
        end
    end

`ifdef DM_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset && store_en)
            $display("%0t@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule
